uart_encode: RTL and testbench
==============================

UART_ENCODE -- requirements
Module: uart_encode

Interface
REQ-001 SHALL have parameter UART_BPS, default 115200: serial bit rate.
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000: sys_clk frequency in Hz.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: address field width, fixed at 8.
REQ-004 SHALL have parameter CMD_WIDTH, default 8: command field width, a multiple of 8, range 8..64.
REQ-005 SHALL have parameter HEAD_FREAME, default 8'hA6: header byte.
REQ-006 SHALL have parameter END_FREAME, default 8'hCE: trailer byte.
REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-008 SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port addr_data, input, ADDR_WIDTH bits: address byte to send.
REQ-010 SHALL have port cmd_data, input, CMD_WIDTH bits: command bytes to send, most significant byte first.
REQ-011 SHALL have port frame_valid, input, 1 bit: upstream requests a frame.
REQ-012 SHALL have port frame_ready, output, 1 bit: encoder can accept a frame.
REQ-013 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the frame completes.
REQ-015 SHALL have port uart_txd, output, 1 bit: serial line, idle high.

Function
REQ-016 Frame SHALL be sent as HEAD_FREAME, then NUM, then addr, then N=CMD_WIDTH/8 command bytes, then END_FREAME, where NUM=1+N as an 8-bit value.
REQ-017 A frame SHALL be accepted on a sys_clk edge where frame_valid=1 and frame_ready=1; addr_data and cmd_data SHALL be captured on that edge and ignored afterwards.
REQ-018 frame_ready SHALL be 1 only in IDLE; frame_valid SHALL be ignored while frame_ready=0.
REQ-019 States SHALL be IDLE, HEAD, NUM, ADDR, CMD, END, plus GAP when the macro is defined; each byte state exits on the sub-module's tx_done.
REQ-020 CMD SHALL use a byte counter of 0..N-1; the state SHALL advance to END when the counter reaches N-1 and tx_done occurs.
REQ-021 The HEAD start bit SHALL begin 2 cycles after acceptance; consecutive bytes SHALL be back-to-back with no idle bits between them.
REQ-022 Each byte SHALL be 8N1 LSB-first, with a bit period of CLK_FREQ/UART_BPS cycles (integer division; 434 at the defaults).
REQ-023 frame_done SHALL pulse in the cycle END's stop bit completes, or the cycle GAP completes; the state SHALL return to IDLE on the next edge.
REQ-024 frame_ready SHALL be 1 the cycle after frame_done; a frame_valid held high SHALL start the next frame then.
REQ-025 busy SHALL be 1 from the cycle after acceptance through the frame_done cycle.

Reset
REQ-026 While sys_rst_n=1: uart_txd=1, frame_ready=0, busy=0, frame_done=0, state=IDLE, counters=0.
REQ-027 Reset asserted mid-frame SHALL force uart_txd high immediately, abandon the frame, and produce no frame_done.
REQ-028 frame_ready SHALL rise on the first sys_clk edge after reset deasserts.

Configuration
REQ-029 With UART_ENCODE_GAP_EN defined, the GAP state SHALL hold uart_txd high for 2 bit periods after END, and frame_done SHALL pulse at the end of GAP.
REQ-030 With UART_ENCODE_GAP_EN undefined, there SHALL be no GAP state, and frame_done SHALL pulse at the end of the END stop bit.

Structure
REQ-031 Shared package uart_pkg SHALL hold the encoder state encodings, default HEAD/END byte constants, and the bit-period computation shared with the receive side.
REQ-032 Sub-module uart_tx SHALL contain the bit-level serializer: ports tx_start, tx_data[7:0], tx_busy, tx_done, uart_txd; parameters BPS and SYS_CLK_FRE.

Verification
REQ-033 Bench: reset release, addr 8'h12, cmd 8'h34 -> bytes A6,02,12,34,CE decoded from the line; frame_done once; total 50 bit periods (21700 cycles).
REQ-034 Bench: CMD_WIDTH=32, cmd 32'hDEADBEEF, addr 8'h01 -> bytes A6,05,01,DE,AD,BE,EF,CE.
REQ-035 Bench: frame_valid held high for 3 frames -> 3 frames back-to-back with a 2-cycle line idle; frame_ready low throughout each frame.
REQ-036 Bench: frame_valid pulsed while busy=1 -> ignored; exactly one frame sent.
REQ-037 Bench: reset asserted during the CMD byte -> uart_txd=1 in the same cycle; no frame_done; a new frame after release is correct.
REQ-038 Bench: with UART_ENCODE_GAP_EN defined -> frame_done 868 cycles after the END stop bit; round-trip through uart_decode yields addr 8'h12 and cmd 8'h34.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: encoder/serializer state encodings, default frame bytes,
// and the bit-period computation used by both transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StNum,
        StAddr,
        StCmd,
        StEnd,
        StGap
    } enc_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    localparam logic [7:0] DEFAULT_HEAD = 8'hA6;
    localparam logic [7:0] DEFAULT_END  = 8'hCE;

    // Clock cycles per serial bit; integer division truncates.
    function automatic int unsigned bit_period(input int unsigned clk_freq,
                                               input int unsigned bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// Bit-level 8N1 serializer, LSB first. A start request seen in the last stop-bit cycle
// launches the next byte with no idle bit; tx_data is sampled at the end of the start bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BPS         = 115200,
    parameter int unsigned SYS_CLK_FRE = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int unsigned BitCycles = bit_period(SYS_CLK_FRE, BPS);
    localparam int unsigned CntW      = $clog2(BitCycles + 1);
    localparam logic [CntW-1:0] BitLast = CntW'(BitCycles - 1);

    tx_state_e       st_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            bit_end;

    assign bit_end = (cnt_q == BitLast);
    assign tx_done = (st_q == TxStop) && bit_end;
    assign tx_busy = (st_q != TxIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= TxIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            uart_txd <= 1'b1;
        end else begin
            cnt_q <= (st_q == TxIdle || bit_end) ? '0 : cnt_q + 1'b1;
            case (st_q)
                TxIdle: begin
                    if (tx_start) begin
                        st_q     <= TxStart;
                        uart_txd <= 1'b0;
                    end
                end
                TxStart: begin
                    if (bit_end) begin
                        shift_q  <= tx_data;
                        uart_txd <= tx_data[0];
                        bit_q    <= '0;
                        st_q     <= TxData;
                    end
                end
                TxData: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
                            uart_txd <= 1'b1;
                            st_q     <= TxStop;
                        end else begin
                            uart_txd <= shift_q[1];
                            shift_q  <= shift_q >> 1;
                            bit_q    <= bit_q + 1'b1;
                        end
                    end
                end
                TxStop: begin
                    if (bit_end) begin
                        if (tx_start) begin
                            st_q     <= TxStart;
                            uart_txd <= 1'b0;
                        end else begin
                            st_q <= TxIdle;
                        end
                    end
                end
                default: st_q <= TxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_encode.sv
// Frame encoder: HEAD, NUM, ADDR, CMD bytes (MSB first), END over a UART line.
// Define UART_ENCODE_GAP_EN to hold the line idle for two bit periods after END.
module uart_encode
    import uart_pkg::*;
#(
    parameter int unsigned UART_BPS    = 115200,
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned CMD_WIDTH   = 8,
    parameter logic [7:0]  HEAD_FREAME = DEFAULT_HEAD,
    parameter logic [7:0]  END_FREAME  = DEFAULT_END
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_data,
    input  logic [CMD_WIDTH-1:0]  cmd_data,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  uart_txd
);

    localparam int unsigned NumCmd  = CMD_WIDTH / 8;
    localparam logic [7:0]  NumByte = 8'(NumCmd + 1);
    localparam logic [2:0]  CmdLast = 3'(NumCmd - 1);

    enc_state_e            state_q;
    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CMD_WIDTH-1:0]  cmd_q;
    logic [2:0]            cnt_q;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;
    logic                  tx_done;

`ifdef UART_ENCODE_GAP_EN
    localparam int unsigned GapCycles = 2 * bit_period(CLK_FREQ, UART_BPS);
    localparam int unsigned GapW      = $clog2(GapCycles);
    localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

    logic [GapW-1:0] gap_q;
    logic            gap_last;

    assign gap_last   = (state_q == StGap) && (gap_q == GapLast);
    assign frame_done = ((state_q == StEnd) && tx_done) || gap_last;
`else
    assign frame_done = (state_q == StEnd) && tx_done;
`endif

    assign frame_ready = ready_q;
    assign busy        = (state_q != StIdle) || tx_busy;
    // Next byte is requested while the current one is still on the line, so they abut.
    assign tx_start    = (state_q inside {StHead, StNum, StAddr, StCmd});

    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            StHead:  tx_data = HEAD_FREAME;
            StNum:   tx_data = NumByte;
            StAddr:  tx_data = addr_q;
            StCmd:   tx_data = cmd_q[CMD_WIDTH-1 -: 8];
            StEnd:   tx_data = END_FREAME;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            addr_q  <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
`ifdef UART_ENCODE_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (ready_q && frame_valid) begin
                        addr_q  <= addr_data;
                        cmd_q   <= cmd_data;
                        ready_q <= 1'b0;
                        state_q <= StHead;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StHead: if (tx_done) state_q <= StNum;
                StNum:  if (tx_done) state_q <= StAddr;
                StAddr: if (tx_done) state_q <= StCmd;
                StCmd: begin
                    if (tx_done) begin
                        cmd_q <= cmd_q << 8;
                        if (cnt_q == CmdLast) begin
                            state_q <= StEnd;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StEnd: begin
                    if (tx_done) begin
`ifdef UART_ENCODE_GAP_EN
                        gap_q   <= '0;
                        state_q <= StGap;
`else
                        ready_q <= 1'b1;
                        state_q <= StIdle;
`endif
                    end
                end
`ifdef UART_ENCODE_GAP_EN
                StGap: begin
                    if (gap_last) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    uart_tx #(
        .BPS         (UART_BPS),
        .SYS_CLK_FRE (CLK_FREQ)
    ) u_tx (
        .clk      (sys_clk),
        .rst      (sys_rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .uart_txd (uart_txd)
    );

endmodule

// File: tb/tb_uart_encode.sv
// Scoreboard bench: stimulus queues expected line bytes and frame_done cycles;
// a line receiver and a frame_done monitor pop and compare independently.
module tb_uart_encode;

    localparam int BitSlow = 434;
    localparam int BitFast = 16;
`ifdef UART_ENCODE_GAP_EN
    localparam int GapBits = 2;
`else
    localparam int GapBits = 0;
`endif

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_byte_t;

    logic clk, rst;
    int   cyc;
    int   n_tests, n_fail;
    int   sel, mon_bit;

    exp_byte_t byte_q[$];
    int        done_q[$];

    logic        valid0, ready0, busy0, done0, txd0;
    logic [7:0]  addr0, cmd0;
    logic        valid1, ready1, busy1, done1, txd1;
    logic [7:0]  addr1;
    logic [31:0] cmd1;
    logic        valid2, ready2, busy2, done2, txd2;
    logic [7:0]  addr2, cmd2;
    logic        mon_txd, mon_done;

    assign mon_txd  = (sel == 0) ? txd0  : (sel == 1) ? txd1  : txd2;
    assign mon_done = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;

    uart_encode u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst), .addr_data(addr0), .cmd_data(cmd0),
        .frame_valid(valid0), .frame_ready(ready0), .busy(busy0),
        .frame_done(done0), .uart_txd(txd0)
    );

    uart_encode #(.UART_BPS(100_000), .CLK_FREQ(1_600_000), .CMD_WIDTH(32)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst), .addr_data(addr1), .cmd_data(cmd1),
        .frame_valid(valid1), .frame_ready(ready1), .busy(busy1),
        .frame_done(done1), .uart_txd(txd1)
    );

    uart_encode #(.UART_BPS(100_000), .CLK_FREQ(1_600_000)) u_dut2 (
        .sys_clk(clk), .sys_rst_n(rst), .addr_data(addr2), .cmd_data(cmd2),
        .frame_valid(valid2), .frame_ready(ready2), .busy(busy2),
        .frame_done(done2), .uart_txd(txd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Queue a frame starting (first start-bit cycle) at s; npush limits bytes queued.
    task automatic push_frame(input int s, input int bit_c, input logic [7:0] addr,
                              input logic [63:0] cmd, input int n, input int npush,
                              output int d);
        logic [7:0] b[12];
        exp_byte_t  e;
        b[0] = 8'hA6;
        b[1] = 8'(n + 1);
        b[2] = addr;
        for (int i = 0; i < n; i++) b[3+i] = cmd[8*(n-1-i) +: 8];
        b[3+n] = 8'hCE;
        for (int i = 0; i < npush; i++) begin
            e.data  = b[i];
            e.start = s + i * 10 * bit_c;
            byte_q.push_back(e);
        end
        d = s + (n + 4) * 10 * bit_c - 1 + GapBits * bit_c;
        if (npush == n + 4) done_q.push_back(d);
    endtask

    // Line receiver.
    initial begin
        int         t, st, idx;
        logic       on;
        logic [7:0] sh;
        exp_byte_t  e;
        on = 1'b0; t = 0; st = 0; sh = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                on = 1'b0;
            end else if (!on) begin
                if (mon_txd == 1'b0) begin
                    on = 1'b1; t = 0; st = cyc;
                end
            end else begin
                t++;
                if (t == mon_bit / 2) begin
                    check("start bit level", 64'(mon_txd), 64'd0);
                end else if (t == mon_bit / 2 + 9 * mon_bit) begin
                    on = 1'b0;
                    check("stop bit level", 64'(mon_txd), 64'd1);
                    if (byte_q.size() == 0) begin
                        check("unexpected byte", 64'(sh), 64'hFFFF);
                    end else begin
                        e = byte_q.pop_front();
                        check("byte data", 64'(sh), 64'(e.data));
                        check("byte start cycle", 64'(st), 64'(e.start));
                    end
                end else if (t > mon_bit / 2 && (t - mon_bit / 2) % mon_bit == 0) begin
                    idx = (t - mon_bit / 2) / mon_bit - 1;
                    sh[idx] = mon_txd;
                end
            end
        end
    end

    // frame_done monitor.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (mon_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("unexpected frame_done", 64'(mon_done), 64'd0);
                end else begin
                    e = done_q.pop_front();
                    check("frame_done cycle", 64'(cyc), 64'(e));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d, d1, d2, d3, rdy_cnt;
        n_tests = 0; n_fail = 0;
        sel = 0; mon_bit = BitSlow;
        rst = 1'b1;
        valid0 = 0; addr0 = '0; cmd0 = '0;
        valid1 = 0; addr1 = '0; cmd1 = '0;
        valid2 = 0; addr2 = '0; cmd2 = '0;

        repeat (3) @(negedge clk);
        check("reset txd0", 64'(txd0), 64'd1);
        check("reset ready0", 64'(ready0), 64'd0);
        check("reset busy0", 64'(busy0), 64'd0);
        check("reset done0", 64'(done0), 64'd0);
        check("reset txd1", 64'(txd1), 64'd1);
        check("reset ready2", 64'(ready2), 64'd0);

        // Default-rate frame straight out of reset, valid already high.
        @(negedge clk);
        k = cyc;
        rst = 1'b0; valid0 = 1; addr0 = 8'h12; cmd0 = 8'h34;
        push_frame(k + 3, BitSlow, 8'h12, 64'h34, 1, 5, d);
        @(negedge clk);
        check("ready after reset release", 64'(ready0), 64'd1);
        @(negedge clk);
        valid0 = 0; addr0 = 8'hEE; cmd0 = 8'hEE;
        check("ready after accept", 64'(ready0), 64'd0);
        check("busy after accept", 64'(busy0), 64'd1);
        wait_cyc(d);
        check("busy in done cycle", 64'(busy0), 64'd1);
        @(negedge clk);
        check("ready after done", 64'(ready0), 64'd1);
        check("busy after done", 64'(busy0), 64'd0);
        check("line idle after done", 64'(txd0), 64'd1);

        // 32-bit command frame.
        sel = 1; mon_bit = BitFast;
        repeat (2) @(negedge clk);
        k = cyc;
        valid1 = 1; addr1 = 8'h01; cmd1 = 32'hDEADBEEF;
        push_frame(k + 2, BitFast, 8'h01, 64'hDEADBEEF, 4, 8, d);
        @(negedge clk);
        valid1 = 0;
        wait_cyc(d + 2);

        // Three back-to-back frames with valid held.
        sel = 2;
        @(negedge clk);
        k = cyc;
        valid2 = 1; addr2 = 8'h12; cmd2 = 8'h34;
        push_frame(k + 2, BitFast, 8'h12, 64'h34, 1, 5, d1);
        push_frame(d1 + 3, BitFast, 8'h12, 64'h34, 1, 5, d2);
        push_frame(d2 + 3, BitFast, 8'h12, 64'h34, 1, 5, d3);
        rdy_cnt = 0;
        do begin
            @(negedge clk);
            if (ready2) rdy_cnt++;
        end while (cyc < d3);
        valid2 = 0;
        check("ready cycles across 3 frames", 64'(rdy_cnt), 64'd2);
        wait_cyc(d3 + 3);

        // Valid pulse while busy is ignored; inputs change after capture.
        k = cyc;
        valid2 = 1; addr2 = 8'hA5; cmd2 = 8'h3C;
        push_frame(k + 2, BitFast, 8'hA5, 64'h3C, 1, 5, d);
        @(negedge clk);
        valid2 = 0; addr2 = 8'hFF; cmd2 = 8'hFF;
        wait_cyc(k + 200);
        valid2 = 1; addr2 = 8'h77;
        check("busy during frame", 64'(busy2), 64'd1);
        check("ready during frame", 64'(ready2), 64'd0);
        @(negedge clk);
        valid2 = 0;
        wait_cyc(d + 12 * BitFast);
        check("no extra bytes", 64'(byte_q.size()), 64'd0);

        // Reset during the CMD byte (first data bit of 8'h34 is 0).
        k = cyc;
        valid2 = 1; addr2 = 8'h12; cmd2 = 8'h34;
        push_frame(k + 2, BitFast, 8'h12, 64'h34, 1, 3, d);
        @(negedge clk);
        valid2 = 0;
        wait_cyc(k + 2 + 31 * BitFast + 3);
        check("line low in cmd bit0", 64'(txd2), 64'd0);
        rst = 1'b1;
        #1;
        check("txd high on async reset", 64'(txd2), 64'd1);
        check("busy cleared on reset", 64'(busy2), 64'd0);
        check("ready cleared on reset", 64'(ready2), 64'd0);
        repeat (4) @(negedge clk);
        check("abandoned bytes drained", 64'(byte_q.size()), 64'd0);
        k = cyc;
        rst = 1'b0; valid2 = 1; addr2 = 8'h5A; cmd2 = 8'hC3;
        push_frame(k + 3, BitFast, 8'h5A, 64'hC3, 1, 5, d);
        @(negedge clk);
        check("ready after mid-frame reset", 64'(ready2), 64'd1);
        @(negedge clk);
        valid2 = 0;
        wait_cyc(d + 20);

        check("byte queue empty", 64'(byte_q.size()), 64'd0);
        check("done queue empty", 64'(done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
